// File: rtl/mem_arbiter.sv
// Two-master (instr/data) arbiter onto one single-port valid/ready memory slave.
// Optional: define MEM_ARBITER_ROUND_ROBIN_EN for last-grant tie-break (default: data wins ties).
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic                    i_valid,
  input  logic                    i_instr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_valid,
  input  logic                    d_instr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    m_valid,
  output logic                    m_instr,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ready,
  output logic                    proto_err
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int RW = 1 + ADDR_WIDTH + DATA_WIDTH + SW;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic          i_pend_reg, d_pend_reg;
  logic [RW-1:0] i_buf_reg, d_buf_reg;
  logic          proto_err_reg;

  logic [RW-1:0] i_in, d_in, m_req;
  logic          i_viol, d_viol, i_new, d_new;
  logic          grant_i, grant_d, from_pend, tie_d;
  logic          resp_i, resp_d;

  assign i_in = {i_instr, i_addr, i_wdata, i_wstrb};
  assign d_in = {d_instr, d_addr, d_wdata, d_wstrb};

  // A second pulse while the same master is queued or in flight is dropped and flagged.
  assign i_viol = i_valid && (i_pend_reg || state_reg == BUSY_I);
  assign d_viol = d_valid && (d_pend_reg || state_reg == BUSY_D);
  assign i_new  = i_valid && !i_viol;
  assign d_new  = d_valid && !d_viol;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic last_d_reg;

  assign tie_d = !last_d_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_d_reg <= 1'b0;
    end else if (grant_i || grant_d) begin
      last_d_reg <= grant_d;
    end
  end
`else
  assign tie_d = 1'b1;
`endif

  always_comb begin
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    from_pend = 1'b0;
    if (state_reg == IDLE) begin
      if (i_pend_reg || d_pend_reg) begin
        from_pend = 1'b1;
        if (i_pend_reg && d_pend_reg) begin
          grant_d = tie_d;
          grant_i = !tie_d;
        end else begin
          grant_d = d_pend_reg;
          grant_i = i_pend_reg;
        end
      end else if (i_new && d_new) begin
        grant_d = tie_d;
        grant_i = !tie_d;
      end else begin
        grant_d = d_new;
        grant_i = i_new;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_d) state_next = BUSY_D;
        else if (grant_i) state_next = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (m_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    m_req = '0;
    if (grant_d) m_req = from_pend ? d_buf_reg : d_in;
    else if (grant_i) m_req = from_pend ? i_buf_reg : i_in;
  end

  // Outputs are forced low while reset is asserted, even before the clearing edge.
  assign m_valid = rst && (grant_i || grant_d);
  assign {m_instr, m_addr, m_wdata, m_wstrb} = rst ? m_req : '0;

  assign resp_i  = rst && state_reg == BUSY_I && m_ready;
  assign resp_d  = rst && state_reg == BUSY_D && m_ready;
  assign i_ready = resp_i;
  assign d_ready = resp_d;
  assign i_rdata = resp_i ? m_rdata : '0;
  assign d_rdata = resp_d ? m_rdata : '0;

  assign proto_err = rst && proto_err_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      i_pend_reg    <= 1'b0;
      d_pend_reg    <= 1'b0;
      i_buf_reg     <= '0;
      d_buf_reg     <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      proto_err_reg <= proto_err_reg || i_viol || d_viol;
      if (grant_i && from_pend) begin
        i_pend_reg <= 1'b0;
      end else if (i_new && !grant_i) begin
        i_pend_reg <= 1'b1;
        i_buf_reg  <= i_in;
      end
      if (grant_d && from_pend) begin
        d_pend_reg <= 1'b0;
      end else if (d_new && !grant_d) begin
        d_pend_reg <= 1'b1;
        d_buf_reg  <= d_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a transaction-level reference model.
// Define MEM_ARBITER_ROUND_ROBIN_EN here too when building the round-robin variant.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  typedef struct packed {
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } req_t;
  typedef struct { int cyc; req_t req; } issue_t;
  typedef struct { int cyc; logic [DW-1:0] rdata; } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_valid = 1'b0, i_instr = 1'b0, d_valid = 1'b0, d_instr = 1'b0;
  logic [AW-1:0] i_addr = '0, d_addr = '0, m_addr;
  logic [DW-1:0] i_wdata = '0, d_wdata = '0, m_wdata, i_rdata, d_rdata;
  logic [SW-1:0] i_wstrb = '0, d_wstrb = '0, m_wstrb;
  logic i_ready, d_ready, m_valid, m_instr, proto_err;
  logic [DW-1:0] m_rdata = '0;
  logic m_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .rst(rst), .clk(clk),
    .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata), .i_wstrb(i_wstrb),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_rdata(m_rdata), .m_ready(m_ready), .proto_err(proto_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  issue_t issue_q[$];
  resp_t  i_resp_q[$];
  resp_t  d_resp_q[$];
  int     ready_at[$];

  // Reference model: index 0 = instr master, 1 = data master; owner -1 = nothing in flight.
  bit   pend_v[2];
  req_t pend_r[2];
  int   owner = -1;
  bit   model_err = 1'b0;
  bit   exp_err_now = 1'b0;
  bit   last_d = 1'b0;
  bit   mbusy[2];
  bit   spurious_en = 1'b0;
  bit   force_en = 1'b0;
  logic [DW-1:0] force_rdata = '0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t q;
    q.instr = 1'($urandom_range(0, 1));
    q.addr  = $urandom;
    q.wdata = $urandom;
    q.wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
    return q;
  endfunction

  function automatic int tie_winner();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return last_d ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  task automatic model_step();
    bit   viol[2];
    bit   inc[2];
    req_t inr[2];
    int   win;
    bit   fromp;
    if (!rst) begin
      exp_err_now = 1'b0;
      model_err = 1'b0;
      owner = -1;
      pend_v = '{1'b0, 1'b0};
      mbusy = '{1'b0, 1'b0};
      last_d = 1'b0;
      return;
    end
    exp_err_now = model_err;
    inc[0] = i_valid;
    inc[1] = d_valid;
    inr[0] = {i_instr, i_addr, i_wdata, i_wstrb};
    inr[1] = {d_instr, d_addr, d_wdata, d_wstrb};
    for (int x = 0; x < 2; x++) begin
      viol[x] = inc[x] && (pend_v[x] || owner == x);
      if (viol[x]) inc[x] = 1'b0;
    end
    win = -1;
    fromp = 1'b0;
    if (owner < 0) begin
      if (pend_v[0] || pend_v[1]) begin
        fromp = 1'b1;
        win = (pend_v[0] && pend_v[1]) ? tie_winner() : (pend_v[1] ? 1 : 0);
      end else if (inc[0] || inc[1]) begin
        win = (inc[0] && inc[1]) ? tie_winner() : (inc[1] ? 1 : 0);
      end
      if (win >= 0) begin
        issue_q.push_back('{cyc, fromp ? pend_r[win] : inr[win]});
        if (fromp) pend_v[win] = 1'b0;
        else inc[win] = 1'b0;
        last_d = (win == 1);
        owner = win;
      end
    end else if (m_ready) begin
      if (owner == 0) i_resp_q.push_back('{cyc, m_rdata});
      else d_resp_q.push_back('{cyc, m_rdata});
      mbusy[owner] = 1'b0;
      owner = -1;
    end
    for (int x = 0; x < 2; x++) begin
      if (inc[x]) begin
        pend_v[x] = 1'b1;
        pend_r[x] = inr[x];
      end
    end
    if (viol[0] || viol[1]) model_err = 1'b1;
  endtask

  task automatic step(input bit r, input bit iv, input req_t ir, input bit dv, input req_t dr);
    req_t g;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    g = rand_req();
    i_valid = iv;
    {i_instr, i_addr, i_wdata, i_wstrb} = iv ? ir : g;
    g = rand_req();
    d_valid = dv;
    {d_instr, d_addr, d_wdata, d_wstrb} = dv ? dr : g;
    m_ready = 1'b0;
    for (int k = ready_at.size() - 1; k >= 0; k--) begin
      if (ready_at[k] == cyc) begin
        m_ready = 1'b1;
        ready_at.delete(k);
      end
    end
    if (spurious_en && !m_ready && ready_at.size() == 0 && owner < 0 && $urandom_range(0, 19) == 0)
      m_ready = 1'b1;
    m_rdata = (m_ready && force_en) ? force_rdata : $urandom;
    if (r && iv) mbusy[0] = 1'b1;
    if (r && dv) mbusy[1] = 1'b1;
    model_step();
  endtask

  task automatic idle(input int n);
    req_t g;
    g = rand_req();
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, g, 1'b0, g);
  endtask

  task automatic wait_free();
    req_t g;
    int k;
    g = rand_req();
    k = 0;
    while ((mbusy[0] || mbusy[1]) && k < 60) begin
      step(1'b1, 1'b0, g, 1'b0, g);
      k++;
    end
    chk(!(mbusy[0] || mbusy[1]), "wait_free_timeout", {mbusy[0], mbusy[1]}, 0);
  endtask

  // Monitor and slave responder: pops expectations whenever the DUT presents an output.
  always @(negedge clk) begin : monitor
    issue_t e;
    resp_t  rsp;
    req_t   mreq;
    mreq = {m_instr, m_addr, m_wdata, m_wstrb};
    if (m_valid) begin
      if (issue_q.size() == 0) begin
        chk(1'b0, "m_issue_unexpected", mreq, 0);
      end else begin
        e = issue_q.pop_front();
        chk(e.cyc == cyc, "m_issue_cycle", cyc, e.cyc);
        chk(e.req == mreq, "m_issue_fields", mreq, e.req);
      end
      ready_at.push_back(cyc + $urandom_range(1, 3));
    end else begin
      chk(mreq == '0, "m_fields_idle_zero", mreq, 0);
    end
    if (i_ready) begin
      if (i_resp_q.size() == 0) begin
        chk(1'b0, "i_ready_unexpected", i_rdata, 0);
      end else begin
        rsp = i_resp_q.pop_front();
        chk(rsp.cyc == cyc, "i_ready_cycle", cyc, rsp.cyc);
        chk(rsp.rdata == i_rdata, "i_rdata", i_rdata, rsp.rdata);
      end
    end else begin
      chk(i_rdata == '0, "i_rdata_zero", i_rdata, 0);
    end
    if (d_ready) begin
      if (d_resp_q.size() == 0) begin
        chk(1'b0, "d_ready_unexpected", d_rdata, 0);
      end else begin
        rsp = d_resp_q.pop_front();
        chk(rsp.cyc == cyc, "d_ready_cycle", cyc, rsp.cyc);
        chk(rsp.rdata == d_rdata, "d_rdata", d_rdata, rsp.rdata);
      end
    end else begin
      chk(d_rdata == '0, "d_rdata_zero", d_rdata, 0);
    end
    chk(proto_err == exp_err_now, "proto_err", proto_err, exp_err_now);
  end

  initial begin
    req_t a, b, b2, g;
    pend_v = '{1'b0, 1'b0};
    mbusy = '{1'b0, 1'b0};
    g = rand_req();
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, g, 1'b0, g);
    idle(2);

    // Uncontended read
    a = rand_req(); a.addr = 32'h100; a.wstrb = '0;
    force_en = 1'b1; force_rdata = 32'hDEADBEEF;
    step(1'b1, 1'b1, a, 1'b0, g);
    wait_free();
    force_en = 1'b0;
    idle(1);

    // Simultaneous requests
    a = rand_req(); a.addr = 32'h200; a.wstrb = '0;
    b = rand_req(); b.addr = 32'h300; b.wstrb = 4'hF;
    step(1'b1, 1'b1, a, 1'b1, b);
    wait_free();
    idle(1);

    // Data request arriving while instr is busy
    a = rand_req(); b = rand_req();
    step(1'b1, 1'b1, a, 1'b0, g);
    step(1'b1, 1'b0, g, 1'b1, b);
    wait_free();
    idle(1);

    // Buffered instr beats a data request arriving in the IDLE cycle
    a = rand_req(); b = rand_req(); b2 = rand_req();
    step(1'b1, 1'b0, g, 1'b1, b);
    step(1'b1, 1'b1, a, 1'b0, g);
    for (int k = 0; k < 20 && mbusy[1]; k++) step(1'b1, 1'b0, g, 1'b0, g);
    step(1'b1, 1'b0, g, 1'b1, b2);
    wait_free();
    idle(1);

    // Repeated ties
    for (int n = 0; n < 4; n++) begin
      a = rand_req(); b = rand_req();
      step(1'b1, 1'b1, a, 1'b1, b);
      wait_free();
      idle(1);
    end

    // Reset while data is in flight and instr is pending
    a = rand_req(); b = rand_req();
    step(1'b1, 1'b0, g, 1'b1, b);
    step(1'b1, 1'b1, a, 1'b0, g);
    step(1'b0, 1'b0, g, 1'b0, g);
    step(1'b0, 1'b0, g, 1'b0, g);
    idle(5);
    a = rand_req();
    step(1'b1, 1'b1, a, 1'b0, g);
    wait_free();
    idle(1);

    // Protocol violation: second data pulse before d_ready
    b = rand_req(); b2 = rand_req();
    step(1'b1, 1'b0, g, 1'b1, b);
    step(1'b1, 1'b0, g, 1'b1, b2);
    wait_free();
    idle(3);
    step(1'b0, 1'b0, g, 1'b0, g);
    idle(2);

    // Randomized traffic with rare resets, violations and spurious slave readies
    spurious_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      bit r, iv, dv;
      r  = ($urandom_range(0, 249) != 0);
      iv = !mbusy[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      dv = !mbusy[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 79) == 0);
      a = rand_req(); b = rand_req();
      step(r, iv, a, dv, b);
    end
    spurious_en = 1'b0;
    wait_free();
    idle(6);

    chk(issue_q.size() == 0, "issue_q_drained", issue_q.size(), 0);
    chk(i_resp_q.size() == 0, "i_resp_q_drained", i_resp_q.size(), 0);
    chk(d_resp_q.size() == 0, "d_resp_q_drained", d_resp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
